// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a START/DATA/STOP serializer.
// Frames are sent LSB first, back-to-back with no idle gap while the FIFO holds bytes.
module uart_tx_fifo #(
  parameter int CLK_DIVIDER = 5208,
  parameter int FIFO_AW     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] write_data,
  input  logic       write_strobe,
  output logic       write_rdy,
  output logic       overflow,
  output logic       serial_out,
  output logic       busy
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIVIDER - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0] count;
  logic [FIFO_AW:0] count_next;
  logic push;
  logic pop;
  logic fifo_empty;

  state_t state;
  state_t state_next;
  logic [15:0] baud_cnt;
  logic [15:0] baud_next;
  logic [2:0] bit_idx;
  logic [2:0] bit_next;
  logic [7:0] shift;
  logic [7:0] shift_next;
  logic tx_next;
  logic tick;

  // A full FIFO refuses the strobe even if the serializer pops in the same cycle.
  assign write_rdy  = (count != FULL_COUNT);
  assign push       = write_strobe & write_rdy;
  assign fifo_empty = (count == '0);
  assign tick       = (baud_cnt == BAUD_LAST);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= write_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      overflow <= write_strobe & ~write_rdy;
      busy     <= (state_next != IDLE) | (count_next != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      serial_out <= 1'b1;
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_idx    <= bit_next;
      shift      <= shift_next;
      serial_out <= tx_next;
    end
  end

  // serial_out is registered, so each branch sets the level for the upcoming bit.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt + 1'b1;
    bit_next   = bit_idx;
    shift_next = shift;
    tx_next    = serial_out;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        baud_next = '0;
        tx_next   = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_next = DATA;
          baud_next  = '0;
          bit_next   = '0;
          tx_next    = shift[0];
        end
      end
      DATA: begin
        if (tick) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next   = bit_idx + 1'b1;
            shift_next = {1'b0, shift[7:1]};
            tx_next    = shift[1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          baud_next = '0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule
